// File: rtl/sdram_traffic_gen_if.sv
// User-side request/ack channel between sdram_traffic_gen (master) and sdram_controller (slave).
interface sdram_traffic_gen_if;
  logic         iinit_done;
  logic         owrite_req;
  logic [21:0]  owrite_address;
  logic [127:0] owrite_data;
  logic         iwrite_ack;
  logic         oread_req;
  logic [21:0]  oread_address;
  logic [127:0] iread_data;
  logic         iread_ack;

  modport master (
    input  iinit_done, iwrite_ack, iread_data, iread_ack,
    output owrite_req, owrite_address, owrite_data, oread_req, oread_address
  );

  modport slave (
    output iinit_done, iwrite_ack, iread_data, iread_ack,
    input  owrite_req, owrite_address, owrite_data, oread_req, oread_address
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// Write-then-readback memory self-test and latency probe for the sdram_controller user port.
// Optional watchdog enabled by defining SDRAM_TRAFFIC_TIMEOUT_EN.
module sdram_traffic_gen #(
  parameter int unsigned NUM_WORDS  = 4,
  parameter logic [21:0] BASE_ADDR  = 22'h000001,
  parameter int unsigned LAT_W      = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                iclk,
  input  logic                ireset_n,
  input  logic                istart,
  sdram_traffic_gen_if.master bus,
  output logic                obusy,
  output logic                odone,
  output logic                opass,
  output logic [15:0]         oerr_count,
  output logic [LAT_W-1:0]    olast_wr_lat,
  output logic [LAT_W-1:0]    olast_rd_lat,
  output logic [LAT_W-1:0]    omax_rd_lat
);

  typedef enum logic [3:0] {
    StIdle, StWaitInit, StWrReq, StWrWait, StWrGap, StRdReq, StRdWait, StRdGap, StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [15:0]      r_index, w_index_d;
  logic [3:0]       r_gap_cnt;
  logic [LAT_W-1:0] r_lat_cnt, r_last_wr, r_last_rd, r_max_rd;
  logic [15:0]      r_err;
  logic             r_pass;
  logic [21:0]      r_wr_addr, r_rd_addr, w_addr_d;
  logic [127:0]     r_wr_data;
  logic             w_start, w_last_word, w_gap_done, w_mismatch, w_timeout_any, w_wdog_fire;

  function automatic logic [127:0] pattern(input logic [21:0] a);
    return {6'b110000, 2'd3, 2'b00, a, 6'b110000, 2'd2, 2'b00, a,
            6'b110000, 2'd1, 2'b00, a, 6'b110000, 2'd0, 2'b00, a};
  endfunction

  assign w_start     = istart && (r_state inside {StIdle, StDone});
  assign w_last_word = (32'(r_index) == NUM_WORDS - 32'd1);
  assign w_gap_done  = (32'(r_gap_cnt) + 32'd1) >= GAP_CYCLES;
  assign w_addr_d    = BASE_ADDR + {6'd0, w_index_d};
  assign w_mismatch  = bus.iread_data != pattern(r_rd_addr);

`ifdef SDRAM_TRAFFIC_TIMEOUT_EN
  logic [19:0] r_wdog;
  logic        r_timeout;
  assign w_wdog_fire   = (r_state inside {StWaitInit, StWrWait, StRdWait}) &&
                         (r_wdog == 20'hFFFFF);
  assign w_timeout_any = r_timeout | w_wdog_fire;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (bus.iwrite_ack || bus.iread_ack) begin
      r_wdog <= '0;
    end else if (w_wdog_fire) begin
      r_timeout <= 1'b1;
    end else if (r_state inside {StWaitInit, StWrWait, StRdWait}) begin
      r_wdog <= r_wdog + 20'd1;
    end
  end
`else
  assign w_wdog_fire   = 1'b0;
  assign w_timeout_any = 1'b0;
`endif

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) r_state <= StIdle;
    else           r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_index_d = r_index;
    unique case (r_state)
      StIdle, StDone: if (w_start) begin
        w_state_d = StWaitInit;
        w_index_d = '0;
      end
      StWaitInit: begin
        if (bus.iinit_done) w_state_d = StWrReq;
        else if (w_wdog_fire) w_state_d = StDone;
      end
      StWrReq: w_state_d = StWrWait;
      StWrWait: begin
        if (bus.iwrite_ack) w_state_d = StWrGap;
        else if (w_wdog_fire) w_state_d = StDone;
      end
      StWrGap: if (w_gap_done) begin
        w_state_d = w_last_word ? StRdReq : StWrReq;
        w_index_d = w_last_word ? 16'd0 : r_index + 16'd1;
      end
      StRdReq: w_state_d = StRdWait;
      StRdWait: begin
        if (bus.iread_ack) w_state_d = StRdGap;
        else if (w_wdog_fire) w_state_d = StDone;
      end
      StRdGap: if (w_gap_done) begin
        w_state_d = w_last_word ? StDone : StRdReq;
        if (!w_last_word) w_index_d = r_index + 16'd1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.owrite_req = (r_state == StWrReq);
    bus.oread_req  = (r_state == StRdReq);
    obusy          = !(r_state inside {StIdle, StDone});
    odone          = (r_state == StDone);
  end

  assign bus.owrite_address = r_wr_addr;
  assign bus.owrite_data    = r_wr_data;
  assign bus.oread_address  = r_rd_addr;
  assign opass              = r_pass;
  assign oerr_count         = r_err;
  assign olast_wr_lat       = r_last_wr;
  assign olast_rd_lat       = r_last_rd;
  assign omax_rd_lat        = r_max_rd;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_index   <= '0;
      r_gap_cnt <= '0;
      r_lat_cnt <= '0;
      r_last_wr <= '0;
      r_last_rd <= '0;
      r_max_rd  <= '0;
      r_err     <= '0;
      r_pass    <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_index   <= w_index_d;
      r_gap_cnt <= (r_state inside {StWrGap, StRdGap}) ? r_gap_cnt + 4'd1 : 4'd0;
      // Latency counts the request cycle as 1, so the counter is preloaded on entry.
      if (w_state_d == StWrReq) begin
        r_wr_addr <= w_addr_d;
        r_wr_data <= pattern(w_addr_d);
        r_lat_cnt <= {{(LAT_W-1){1'b0}}, 1'b1};
      end else if (w_state_d == StRdReq) begin
        r_rd_addr <= w_addr_d;
        r_lat_cnt <= {{(LAT_W-1){1'b0}}, 1'b1};
      end else if ((r_state inside {StWrReq, StWrWait, StRdReq, StRdWait}) &&
                   (r_lat_cnt != {LAT_W{1'b1}})) begin
        r_lat_cnt <= r_lat_cnt + {{(LAT_W-1){1'b0}}, 1'b1};
      end
      if (w_start) begin
        r_err    <= '0;
        r_max_rd <= '0;
        r_pass   <= 1'b0;
      end
      if (r_state == StWrWait && bus.iwrite_ack) r_last_wr <= r_lat_cnt;
      if (r_state == StRdWait && bus.iread_ack) begin
        r_last_rd <= r_lat_cnt;
        if (r_lat_cnt > r_max_rd) r_max_rd <= r_lat_cnt;
        if (w_mismatch && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      end
      if (w_state_d == StDone && r_state != StDone)
        r_pass <= (r_err == 16'd0) && !w_timeout_any;
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench: controller/echo-memory models around two traffic generators (default and wrap).
module tb_sdram_traffic_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  sdram_traffic_gen_if if0 ();
  sdram_traffic_gen_if if1 ();

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, lw0, lr0, mx0, err1, lw1, lr1, mx1;

  sdram_traffic_gen u_dut0 (
    .iclk(clk), .ireset_n(rst_n), .istart(start0), .bus(if0.master),
    .obusy(busy0), .odone(done0), .opass(pass0), .oerr_count(err0),
    .olast_wr_lat(lw0), .olast_rd_lat(lr0), .omax_rd_lat(mx0)
  );

  sdram_traffic_gen #(.BASE_ADDR(22'h3FFFFE)) u_dut1 (
    .iclk(clk), .ireset_n(rst_n), .istart(start1), .bus(if1.master),
    .obusy(busy1), .odone(done1), .opass(pass1), .oerr_count(err1),
    .olast_wr_lat(lw1), .olast_rd_lat(lr1), .omax_rd_lat(mx1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [21:0] a);
    return {8'hC3, 2'b00, a, 8'hC2, 2'b00, a, 8'hC1, 2'b00, a, 8'hC0, 2'b00, a};
  endfunction

  // Model for dut0: programmable ack delays, echo memory, optional bit-0 corruption.
  int           wdelay = 3, wcnt = 0, rcnt = 0, rn = 0;
  int           rdel[4] = '{3, 3, 3, 3};
  logic [21:0]  waddr, raddr, bad_addr = 22'd0;
  logic [127:0] wdata;
  logic [127:0] mem0 [logic [21:0]];
  logic [21:0]  wlog[$], rlog[$];
  logic [127:0] dlog[$];
  logic         stray = 1'b0;

  always @(negedge clk) begin
    if0.iwrite_ack = stray;
    if0.iread_ack  = stray;
    if0.iread_data = '0;
    if (!rst_n) begin
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          if0.iwrite_ack = 1'b1;
          mem0[waddr] = wdata;
          check("wr_addr_hold", 128'(if0.owrite_address), 128'(waddr));
          check("wr_data_hold", if0.owrite_data, wdata);
        end
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          if0.iread_ack  = 1'b1;
          if0.iread_data = (mem0.exists(raddr) ? mem0[raddr] : 128'd0) ^
                           {127'd0, raddr == bad_addr};
        end
      end
      if (if0.owrite_req) begin
        wcnt  = wdelay;
        waddr = if0.owrite_address;
        wdata = if0.owrite_data;
        wlog.push_back(waddr);
        dlog.push_back(wdata);
      end
      if (if0.oread_req) begin
        rcnt  = rdel[rn % 4];
        rn++;
        raddr = if0.oread_address;
        rlog.push_back(raddr);
      end
    end
  end

  // Model for dut1: ack one cycle after each request, echo memory.
  logic         w1p = 1'b0, r1p = 1'b0;
  logic [21:0]  w1a, r1a;
  logic [127:0] w1d;
  logic [127:0] mem1 [logic [21:0]];
  logic [21:0]  w1log[$], r1log[$];
  logic [127:0] d1log[$];

  always @(negedge clk) begin
    if1.iwrite_ack = 1'b0;
    if1.iread_ack  = 1'b0;
    if1.iread_data = '0;
    if (rst_n) begin
      if (w1p) begin
        if1.iwrite_ack = 1'b1;
        mem1[w1a] = w1d;
        w1p = 1'b0;
      end
      if (r1p) begin
        if1.iread_ack  = 1'b1;
        if1.iread_data = mem1.exists(r1a) ? mem1[r1a] : 128'd0;
        r1p = 1'b0;
      end
      if (if1.owrite_req) begin
        w1p = 1'b1; w1a = if1.owrite_address; w1d = if1.owrite_data;
        w1log.push_back(w1a);
        d1log.push_back(w1d);
      end
      if (if1.oread_req) begin
        r1p = 1'b1; r1a = if1.oread_address;
        r1log.push_back(r1a);
      end
    end
  end

  typedef struct {
    int          wd;
    int          rd[4];
    logic [21:0] bad;
    logic [15:0] err;
    logic        pass;
    logic [15:0] lw, lr, mx;
  } vec_t;

  vec_t vecs[5];

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 128'(busy0), 128'd0);
    check({tag, "_done"}, 128'(done0), 128'd0);
    check({tag, "_pass"}, 128'(pass0), 128'd0);
    check({tag, "_err"}, 128'(err0), 128'd0);
    check({tag, "_lw"}, 128'(lw0), 128'd0);
    check({tag, "_lr"}, 128'(lr0), 128'd0);
    check({tag, "_mx"}, 128'(mx0), 128'd0);
    check({tag, "_wreq"}, 128'(if0.owrite_req), 128'd0);
    check({tag, "_rreq"}, 128'(if0.oread_req), 128'd0);
    check({tag, "_waddr"}, 128'(if0.owrite_address), 128'd0);
    check({tag, "_wdata"}, if0.owrite_data, 128'd0);
    check({tag, "_raddr"}, 128'(if0.oread_address), 128'd0);
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    while (!done0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 128'(done0), 128'd1);
    check({tag, "_busy_low"}, 128'(busy0), 128'd0);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic check_addrs0(input string tag, input logic [21:0] first);
    check({tag, "_nwr"}, 128'(wlog.size()), 128'd4);
    check({tag, "_nrd"}, 128'(rlog.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_waddr%0d", tag, k), 128'(wlog.size() > k ? wlog[k] : 22'bx),
            128'(first + 22'(k)));
      check($sformatf("%s_raddr%0d", tag, k), 128'(rlog.size() > k ? rlog[k] : 22'bx),
            128'(first + 22'(k)));
    end
  endtask

  initial begin
    vecs[0] = '{wd: 3, rd: '{3, 3, 3, 3}, bad: 22'd3, err: 16'd1, pass: 1'b0,
                lw: 16'd4, lr: 16'd4, mx: 16'd4};
    vecs[1] = '{wd: 1, rd: '{1, 6, 2, 4}, bad: 22'd0, err: 16'd0, pass: 1'b1,
                lw: 16'd2, lr: 16'd5, mx: 16'd7};
    vecs[2] = '{wd: 5, rd: '{4, 1, 1, 1}, bad: 22'd1, err: 16'd1, pass: 1'b0,
                lw: 16'd6, lr: 16'd2, mx: 16'd5};
    vecs[3] = '{wd: 2, rd: '{2, 2, 2, 9}, bad: 22'd4, err: 16'd1, pass: 1'b0,
                lw: 16'd3, lr: 16'd10, mx: 16'd10};
    vecs[4] = '{wd: 3, rd: '{3, 3, 3, 3}, bad: 22'd0, err: 16'd0, pass: 1'b1,
                lw: 16'd4, lr: 16'd4, mx: 16'd4};
    if0.iinit_done = 1'b0;
    if1.iinit_done = 1'b0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First run: init_done arrives 100 cycles after start.
    pulse_start0();
    repeat (100) @(negedge clk);
    check("init_wait_busy", 128'(busy0), 128'd1);
    check("init_wait_nowr", 128'(wlog.size()), 128'd0);
    if0.iinit_done = 1'b1;
    wait_done0("run1");
    check("run1_pass", 128'(pass0), 128'd1);
    check("run1_err", 128'(err0), 128'd0);
    check("run1_lw", 128'(lw0), 128'd4);
    check("run1_lr", 128'(lr0), 128'd4);
    check("run1_data0", dlog.size() > 0 ? dlog[0] : 128'bx,
          128'hC3000001_C2000001_C1000001_C0000001);
    check("run1_data3", dlog.size() > 3 ? dlog[3] : 128'bx, pat(22'd4));
    check_addrs0("run1", 22'd1);
    repeat (3) @(negedge clk);
    check("run1_done_hold", 128'(done0), 128'd1);

    for (int i = 0; i < 5; i++) begin
      wdelay = vecs[i].wd;
      rdel = vecs[i].rd;
      bad_addr = vecs[i].bad;
      rn = 0;
      pulse_start0();
      check($sformatf("row%0d_start_busy", i), 128'(busy0), 128'd1);
      check($sformatf("row%0d_start_done", i), 128'(done0), 128'd0);
      @(negedge clk);
      check($sformatf("row%0d_wreq_timing", i), 128'(if0.owrite_req), 128'd1);
      wait_done0($sformatf("row%0d", i));
      check($sformatf("row%0d_err", i), 128'(err0), 128'(vecs[i].err));
      check($sformatf("row%0d_pass", i), 128'(pass0), 128'(vecs[i].pass));
      check($sformatf("row%0d_lw", i), 128'(lw0), 128'(vecs[i].lw));
      check($sformatf("row%0d_lr", i), 128'(lr0), 128'(vecs[i].lr));
      check($sformatf("row%0d_mx", i), 128'(mx0), 128'(vecs[i].mx));
    end

    // Reset during the second write's wait phase.
    wdelay = 6; rdel = '{3, 3, 3, 3}; bad_addr = 22'd0; rn = 0;
    wlog.delete(); rlog.delete();
    pulse_start0();
    for (int n = 0; n < 200 && wlog.size() < 2; n++) @(negedge clk);
    check("mid_second_wr_seen", 128'(wlog.size()), 128'd2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wlog.delete(); rlog.delete();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_busy", 128'(busy0), 128'd0);
    check("stray_done", 128'(done0), 128'd0);
    check("stray_err", 128'(err0), 128'd0);
    check("stray_lw", 128'(lw0), 128'd0);
    check("stray_nowr", 128'(wlog.size()), 128'd0);
    wdelay = 3;
    pulse_start0();
    wait_done0("clean");
    check("clean_pass", 128'(pass0), 128'd1);
    check("clean_err", 128'(err0), 128'd0);
    check_addrs0("clean", 22'd1);

    // Address wrap on the second instance.
    if1.iinit_done = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 2000 && !done1; n++) @(negedge clk);
    check("wrap_done", 128'(done1), 128'd1);
    check("wrap_pass", 128'(pass1), 128'd1);
    check("wrap_err", 128'(err1), 128'd0);
    check("wrap_lw", 128'(lw1), 128'd2);
    check("wrap_nwr", 128'(w1log.size()), 128'd4);
    begin
      logic [21:0] exp_a[4];
      exp_a = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000, 22'h000001};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("wrap_waddr%0d", k), 128'(w1log.size() > k ? w1log[k] : 22'bx),
              128'(exp_a[k]));
        check($sformatf("wrap_raddr%0d", k), 128'(r1log.size() > k ? r1log[k] : 22'bx),
              128'(exp_a[k]));
      end
    end
    check("wrap_data2", d1log.size() > 2 ? d1log[2] : 128'bx,
          128'hC3000000_C2000000_C1000000_C0000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_traffic_gen.md
Name: sdram_traffic_gen

Overview:
Synthesizable initiator for the sdram_controller user interface: the hardware counterpart of the bench that drives the controller's write/read request ports. On start it waits for oinit_done, writes NUM_WORDS 128-bit pattern words to consecutive addresses, then reads each one back. It compares each read against the regenerated pattern and reports pass/fail, mismatch count and per-access cycle latencies. It sits beside sdram_controller as an on-chip memory self-test and bandwidth probe.

Parameters:
NUM_WORDS, 4, number of words written then read back (1..2^16-1)
BASE_ADDR, 22'h000001, first address; word n uses BASE_ADDR+n, wrapping modulo 2^22
LAT_W, 16, width of latency counters; counters saturate at all-ones
GAP_CYCLES, 1, idle cycles between an ack and the next request (0..15)

Ports:
iclk  in  1  system clock
ireset_n  in  1  asynchronous active-low reset
istart  in  1  one-cycle pulse; starts a run when idle or done
iinit_done  in  1  controller oinit_done
owrite_req  out  1  one-cycle write request pulse
owrite_address  out  22  write address, held from request until ack
owrite_data  out  128  write data, held from request until ack
iwrite_ack  in  1  controller owrite_ack
oread_req  out  1  one-cycle read request pulse
oread_address  out  22  read address, held from request until ack
iread_data  in  128  controller oread_data, valid in the iread_ack cycle
iread_ack  in  1  controller oread_ack
obusy  out  1  high from the accepted istart until DONE
odone  out  1  high in DONE until the next istart
opass  out  1  valid when odone: 1 iff zero mismatches and no timeout
oerr_count  out  16  read mismatch count, saturating
olast_wr_lat  out  LAT_W  cycles of the most recent write
olast_rd_lat  out  LAT_W  cycles of the most recent read
omax_rd_lat  out  LAT_W  maximum read latency this run

Behaviour:
- Reset (async, ireset_n=0): state IDLE; every output 0, addresses and data 0, counters 0.
- Pattern: word(a) = {L3,L2,L1,L0}, with Lk = {6'b110000, k[1:0], 2'b00, a[21:0]}. For a=1: 128'hC3000001_C2000001_C1000001_C0000001.
- States: IDLE -> WAIT_INIT -> WR_REQ -> WR_WAIT -> WR_GAP -> (WR_REQ | RD_REQ) -> RD_WAIT -> RD_GAP -> (RD_REQ | DONE).
- IDLE/DONE: istart -> WAIT_INIT; clears oerr_count, omax_rd_lat, index and opass; sets obusy; drops odone. istart is ignored in all other states.
- WAIT_INIT: advance to WR_REQ in the cycle after iinit_done is sampled high. An already-high iinit_done gives a 1-cycle stay.
- WR_REQ: owrite_req=1 for exactly one cycle; address/data driven this cycle; latency counter loaded with 1; go to WR_WAIT.
- WR_WAIT: counter increments each cycle; on iwrite_ack, olast_wr_lat = counter; go to WR_GAP. An ack in the WR_REQ cycle itself is ignored.
- GAP states: wait GAP_CYCLES cycles (GAP_CYCLES=0 means next cycle). After the last write, reset index to 0 and go to RD_REQ; after the last read, go to DONE.
- RD_REQ/RD_WAIT: mirror the write states. On iread_ack, compare iread_data with word(oread_address). On mismatch, oerr_count+1 (saturating at 16'hFFFF). Update olast_rd_lat; omax_rd_lat = max.
- Latency = cycles from the request cycle (counted as 1) through the ack cycle inclusive. Example: ack 3 cycles after the req cycle gives latency 4.
- Acks arriving in IDLE, GAP, WAIT_INIT or DONE are ignored and are not errors.
- DONE: obusy=0, odone=1, opass=(oerr_count==0 && !timeout); outputs hold.
- Reset mid-run: immediate return to IDLE with all outputs cleared; no request pulse is emitted in the reset cycle.

Optional Feature:
SDRAM_TRAFFIC_TIMEOUT_EN:
- Defined: a 20-bit watchdog counts cycles in WR_WAIT/RD_WAIT/WAIT_INIT and clears on each ack. When it reaches 20'hFFFFF, the block sets an internal timeout flag, jumps to DONE, and reports opass=0.
- Undefined: no watchdog exists; the block waits indefinitely.

Test Plan:
- Default params; init_done after 100 cycles; controller model acks 3 cycles after each req; echo memory -> 4 writes to addr 1..4 with owrite_data for addr 1 = 128'hC3000001_C2000001_C1000001_C0000001. Expected: olast_wr_lat=4, olast_rd_lat=4, oerr_count=0, opass=1, odone=1.
- Memory model flips bit 0 of the addr-3 word on readback -> oerr_count=1, opass=0; other three reads match.
- BASE_ADDR=22'h3FFFFE, NUM_WORDS=4 -> addresses 3FFFFE, 3FFFFF, 000000, 000001 in that order; opass=1.
- Read acks at latencies 2, 7, 3, 5 -> omax_rd_lat=7, olast_rd_lat=5.
- Drop ireset_n during the second write's WR_WAIT -> all outputs 0 asynchronously. Stray ack in IDLE is ignored. Then istart -> a clean full run with opass=1.
- With SDRAM_TRAFFIC_TIMEOUT_EN defined and a model that never acks reads -> DONE reached 2^20-1 cycles after the first oread_req, opass=0. Without the macro, obusy stays 1.
